alu_share_arbiter: RTL and testbench

//  Shares one ALU instance (3-bit ALUcontrol: 000 add, 001 sub, 010 and, 011 or, 101 slt) between two requesters.

---
 rtl/alu_share_arbiter.sv | 102 ++++++++++
 tb/tb_alu_share_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two valid/ready requesters and buffers one response; define ALU_ARB_OPCHK_EN to reject opcodes 100/110/111
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic last_grant, idle, g0, g1, hs, bad;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0] sel_op;
  always_comb begin
    idle = state == IDLE;
    g0 = req0_valid && (!req1_valid || PRIO_MODE != 0 || last_grant);
    g1 = req1_valid && !g0;
    hs = idle && (g0 || g1);
    sel_a = g1 ? req1_a : req0_a;
    sel_b = g1 ? req1_b : req0_b;
    sel_op = g1 ? req1_op : req0_op;
  end
`ifdef ALU_ARB_OPCHK_EN
  assign bad = sel_op == 3'b100 || sel_op[2:1] == 2'b11;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp_err <= 1'b0;
    else if (hs) rsp_err <= bad;
`else
  assign bad = 1'b0;
  assign rsp_err = 1'b0;
`endif
  assign req0_ready = idle && g0;
  assign req1_ready = idle && g1;
  assign busy = !idle;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= 3'b000;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_flags <= 4'b0000;
    end else begin
      case (state)
        IDLE: if (hs) begin
          rsp_id <= g1;
          last_grant <= g1;
          if (bad) begin
            rsp_result <= '0;
            rsp_flags <= 4'b0000;
            rsp_valid <= 1'b1;
            state <= RESP;
          end else begin
            alu_a <= sel_a;
            alu_b <= sel_b;
            alu_ctrl <= sel_op;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags <= {alu_zero, alu_carry, alu_neg, alu_ovf};
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized and directed checks of both arbitration modes against a reference model
module tb_alu_share_arbiter;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0] op0 = '0, op1 = '0;
  logic [1:0] rdy0, rdy1, rv, rid, rerr, bsy, azero, acarry, aneg, aovf;
  logic [1:0][W-1:0] aa, ab, ares, rres;
  logic [1:0][2:0] actl;
  logic [1:0][3:0] rflg;
  int n_cmp = 0, n_bad = 0;
  bit lg = 1'b1;
  always #5 clk = ~clk;
  function automatic logic [W+3:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    logic [W-1:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'b001: begin r = a - b; c = a >= b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = W'($signed(a) < $signed(b));
      default: r = '0;
    endcase
    return {r, r == '0, c, r[W-1], v};
  endfunction
  function automatic bit illegal(input logic [2:0] op);
`ifdef ALU_ARB_OPCHK_EN
    return op == 3'b100 || op == 3'b110 || op == 3'b111;
`else
    return 1'b0;
`endif
  endfunction
  for (genvar g = 0; g < 2; g++) begin : d
    assign {ares[g], azero[g], acarry[g], aneg[g], aovf[g]} = alu_fn(actl[g], aa[g], ab[g]);
    alu_share_arbiter #(.WIDTH(W), .PRIO_MODE(g)) u (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0[g]), .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .req1_valid(v1), .req1_ready(rdy1[g]), .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .alu_a(aa[g]), .alu_b(ab[g]), .alu_ctrl(actl[g]), .alu_result(ares[g]),
      .alu_zero(azero[g]), .alu_carry(acarry[g]), .alu_neg(aneg[g]), .alu_ovf(aovf[g]),
      .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_id(rid[g]), .rsp_result(rres[g]),
      .rsp_flags(rflg[g]), .rsp_err(rerr[g]), .busy(bsy[g]));
  end
  task automatic chk(input string tag, input logic [W+3:0] obs, input logic [W+3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic issue(input bit nv0, input logic [W-1:0] na0, input logic [W-1:0] nb0, input logic [2:0] nop0,
                       input bit nv1, input logic [W-1:0] na1, input logic [W-1:0] nb1, input logic [2:0] nop1,
                       input int stall);
    int waited, lat[2], exp_lat[2];
    bit gr[2];
    logic [W+3:0] exp_rf[2];
    v0 = nv0; a0 = na0; b0 = nb0; op0 = nop0;
    v1 = nv1; a1 = na1; b1 = nb1; op1 = nop1;
    #1;
    waited = 0;
    while (!(rdy0[0] || rdy1[0]) && waited < 10) begin
      tick;
      waited++;
    end
    chk("handshake_wait", 36'(waited < 10), 36'(1));
    for (int m = 0; m < 2; m++) begin
      gr[m] = (nv0 && nv1) ? (m == 1 ? 1'b0 : !lg) : nv1;
      chk($sformatf("grant_m%0d", m), 36'({rdy1[m], rdy0[m]}), 36'(gr[m] ? 2'b10 : 2'b01));
      exp_lat[m] = illegal(gr[m] ? nop1 : nop0) ? 1 : 2;
      exp_rf[m] = illegal(gr[m] ? nop1 : nop0) ? '0 : (gr[m] ? alu_fn(nop1, na1, nb1) : alu_fn(nop0, na0, nb0));
      lat[m] = 0;
    end
    lg = gr[0];
    for (int t = 1; t <= 2; t++) begin
      tick;
      for (int m = 0; m < 2; m++) if (rv[m] && lat[m] == 0) lat[m] = t;
    end
    for (int s = 0; s <= stall; s++) begin
      for (int m = 0; m < 2; m++) begin
        if (s == 0) chk($sformatf("latency_m%0d", m), 36'(lat[m]), 36'(exp_lat[m]));
        chk($sformatf("rsp_valid_m%0d", m), 36'(rv[m]), 36'(1));
        chk($sformatf("rsp_id_m%0d", m), 36'(rid[m]), 36'(gr[m]));
        chk($sformatf("rsp_rf_m%0d", m), {rres[m], rflg[m]}, exp_rf[m]);
        chk($sformatf("rsp_err_m%0d", m), 36'(rerr[m]), 36'(exp_lat[m] == 1));
        chk($sformatf("resp_ready_busy_m%0d", m), 36'({rdy1[m], rdy0[m], bsy[m]}), 36'(3'b001));
      end
      if (s < stall) tick;
    end
    v0 = 1'b0; v1 = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    for (int m = 0; m < 2; m++) chk($sformatf("released_m%0d", m), 36'({rv[m], bsy[m]}), 36'(2'b00));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] ops[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    logic [2:0] rop0, rop1;
    bit rv0, rv1;
    tick;
    tick;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset_rsp_m%0d", m), 36'({rv[m], rid[m], rerr[m], bsy[m], rflg[m]}), 36'(0));
      chk($sformatf("reset_res_m%0d", m), 36'(rres[m]), 36'(0));
      chk($sformatf("reset_alu_m%0d", m), 36'({aa[m] | ab[m], actl[m]}), 36'(0));
    end
    rst_n = 1'b1;
    tick;
    chk("idle_no_ready", 36'({rdy0, rdy1}), 36'(0));
    issue(1, 32'd5, 32'd7, 3'b000, 0, '0, '0, 3'b000, 0);
    issue(0, '0, '0, 3'b000, 1, 32'd5, 32'd5, 3'b001, 0);
    issue(0, '0, '0, 3'b000, 1, 32'd3, 32'd5, 3'b001, 0);
    for (int i = 0; i < 4; i++) issue(1, 32'd10, 32'd3, 3'b001, 1, 32'h0F, 32'h33, 3'b010, 0);
    issue(1, 32'hF0F0, 32'h0F00, 3'b011, 0, '0, '0, 3'b000, 5);
    issue(1, 32'h7FFFFFFF, 32'd1, 3'b000, 0, '0, '0, 3'b000, 0);
    issue(1, '0, '0, 3'b111, 0, '0, '0, 3'b000, 1);
    issue(0, '0, '0, 3'b000, 1, 32'd9, 32'd2, 3'b100, 0);
    issue(1, 32'd1, 32'd2, 3'b000, 0, '0, '0, 3'b000, 0);
    v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; op0 = 3'b000;
    tick;
    v0 = 1'b0;
    chk("exec_busy", 36'(bsy[0]), 36'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset", 36'({rv[0], bsy[0], rv[1], bsy[1]}), 36'(0));
    tick;
    rst_n = 1'b1;
    lg = 1'b1;
    tick;
    chk("no_rsp_after_reset", 36'({rv, bsy}), 36'(0));
    issue(1, 32'hF0, 32'h0F, 3'b011, 1, 32'd1, 32'd1, 3'b000, 0);
    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1'b1;
      rop0 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : ops[$urandom_range(0, 4)];
      rop1 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : ops[$urandom_range(0, 4)];
      issue(rv0, ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 9)) : W'($urandom),
            ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 9)) : W'($urandom), rop0,
            rv1, W'($urandom), W'($urandom), rop1, $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
